// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg
// Shared types and defaults for the CPU memory-port arbiter slice.
//   state_t  : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   owner_t  : which requester currently owns the memory port
//   MEM_LAT_DEF / STARVE_MAX_DEF : default parameter values
//   LAT_W    : width of the WAIT-state latency counter
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam int MEM_LAT_DEF    = 2;
  localparam int STARVE_MAX_DEF = 4;
  localparam int LAT_W          = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the fetch port, the data port and the shared memory port.
//   slave  modport : the arbiter's view (requests in, responses/memory out)
//   master modport : the environment's view (CPU stages plus memory)
//
// Handshake: a requester raises *_req with its address (and, for data,
// we/wdata) and holds them until the matching *_valid pulse, which lasts
// exactly one cycle and carries *_rdata. The request is then dropped or
// renewed by the next clock edge. Inputs are only looked at while the
// arbiter is idle, so changing them while a request is in flight is
// harmless. mem_rdata must be valid MEM_LAT cycles after the mem_en cycle.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_rdata;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_valid;
  logic [31:0] dm_rdata;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        stall_if;
  logic        stall_dm;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_valid, if_rdata, dm_valid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_dm
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_valid, if_rdata, dm_valid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_dm
  );
endinterface

// File: rtl/mem_lat_counter.sv
// mem_lat_counter
// Down-counter that times the WAIT phase of a memory access.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : load load_val (asserted during ISSUE)
//   load_val   : number of WAIT cycles
//   en         : count down (asserted during WAIT)
//   done       : high in the last WAIT cycle (count == 1)
module mem_lat_counter
  import cpu_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [LAT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - LAT_W'(1);
    end
  end

  // The count holds the number of WAIT cycles still to go, including the
  // current one, so a value of 1 marks the final cycle.
  assign done = (cnt == LAT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one fixed-latency memory port between instruction fetch and the
// data stage. Each access runs IDLE -> ISSUE -> WAIT (MEM_LAT cycles) ->
// RESP, giving a request-to-valid latency of MEM_LAT+2 cycles.
// Data wins ties unless fetch has been passed over STARVE_MAX times.
//   MEM_LAT    : memory read latency in cycles, 1..15
//   STARVE_MAX : data grants allowed while fetch waits, 1..15
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : fetch, data and memory signals (slave modport)
//   dbg_state  : current FSM state, for observation only
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_port_arbiter_if.slave     bus,
  output state_t                dbg_state
);

  localparam logic [LAT_W-1:0] LAT_LOAD   = LAT_W'(MEM_LAT);
  localparam logic [LAT_W-1:0] STARVE_LIM = LAT_W'(STARVE_MAX);

  state_t           state;
  owner_t           owner;
  logic             lat_we;      // latched write flag of the access in flight
  logic [LAT_W-1:0] starve_cnt;  // data grants made while fetch was waiting
  logic             lat_done;
  logic             any_req;
  logic             grant_dm;

  mem_lat_counter u_lat (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == ISSUE),
    .load_val (LAT_LOAD),
    .en       (state == WAIT),
    .done     (lat_done)
  );

  assign any_req  = bus.if_req | bus.dm_req;
  // Data normally wins; once fetch has been skipped STARVE_MAX times in a
  // row it gets the next slot.
  assign grant_dm = bus.dm_req & ~(bus.if_req & (starve_cnt == STARVE_LIM));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      lat_we     <= 1'b0;
      starve_cnt <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_valid  <= 1'b0;
      bus.if_rdata  <= '0;
      bus.dm_valid  <= 1'b0;
      bus.dm_rdata  <= '0;
    end else begin
      // Strobes are one-cycle pulses unless set below.
      bus.mem_en   <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.if_valid <= 1'b0;
      bus.dm_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= ISSUE;
            bus.mem_en <= 1'b1;
            if (grant_dm) begin
              owner         <= OWN_DM;
              lat_we        <= bus.dm_we;
              bus.mem_we    <= bus.dm_we;
              bus.mem_addr  <= bus.dm_addr;
              bus.mem_wdata <= bus.dm_wdata;
              if (bus.if_req && (starve_cnt < STARVE_LIM)) begin
                starve_cnt <= starve_cnt + LAT_W'(1);
              end
            end else begin
              // A fetch never writes; mem_wdata keeps its last value.
              owner        <= OWN_IF;
              lat_we       <= 1'b0;
              bus.mem_addr <= bus.if_addr;
              starve_cnt   <= '0;
            end
          end
        end

        ISSUE: begin
          state <= WAIT;
        end

        WAIT: begin
          if (lat_done) begin
            state <= RESP;
            if (owner == OWN_IF) begin
              bus.if_valid <= 1'b1;
              bus.if_rdata <= bus.mem_rdata;
            end else begin
              bus.dm_valid <= 1'b1;
              // Stores acknowledge without disturbing the last load data.
              if (!lat_we) begin
                bus.dm_rdata <= bus.mem_rdata;
              end
            end
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.stall_if = bus.if_req & ~bus.if_valid;
  assign bus.stall_dm = bus.dm_req & ~bus.dm_valid;
  assign dbg_state    = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter: a schedule-based reference model
// predicts every output each cycle, and literal expectations pin the key
// timings (fetch, collision, store, starvation, reset, latency variants).
module tb_mem_port_arbiter;
  import cpu_mem_pkg::*;

  localparam int MEM_LAT    = MEM_LAT_DEF;
  localparam int STARVE_MAX = STARVE_MAX_DEF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if a ();
  mem_port_arbiter_if l1 ();
  mem_port_arbiter_if l5 ();
  state_t dbg_state, dbg_l1, dbg_l5;

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .bus(a), .dbg_state(dbg_state));
  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(STARVE_MAX)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .bus(l1), .dbg_state(dbg_l1));
  mem_port_arbiter #(.MEM_LAT(5), .STARVE_MAX(STARVE_MAX)) dut_l5 (
    .clk(clk), .rst_n(rst_n), .bus(l5), .dbg_state(dbg_l5));

  // Memory behind the latency variants: data depends only on the held address.
  assign l1.mem_rdata = {16'hA5A5, l1.mem_addr[15:0]};
  assign l5.mem_rdata = {16'hA5A5, l5.mem_addr[15:0]};

  // ---------------- memory contents ----------------
  function automatic logic [31:0] mem_init(input logic [31:0] addr);
    return (addr == 32'h10) ? 32'h8C01_0004 : {16'hA5A5, addr[15:0]};
  endfunction

  // Responder for the main DUT: data appears only in the cycle MEM_LAT after
  // mem_en, garbage otherwise.
  logic [31:0] wr_mem[logic [31:0]];
  logic [31:0] rsp_pend = '0;
  logic [3:0]  rsp_cnt = '0;
  function automatic logic [31:0] mem_read(input logic [31:0] addr);
    return wr_mem.exists(addr) ? wr_mem[addr] : mem_init(addr);
  endfunction
  always @(posedge clk) begin
    if (a.mem_en) begin
      if (a.mem_we) wr_mem[a.mem_addr] = a.mem_wdata;
      else rsp_pend <= mem_read(a.mem_addr);
      rsp_cnt <= 4'(MEM_LAT);
    end else if (rsp_cnt != 0) begin
      rsp_cnt <= rsp_cnt - 4'd1;
    end
  end
  assign a.mem_rdata = (rsp_cnt == 4'd1) ? rsp_pend : 32'hBAD0_BAD0;

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Each grant occupies the port for MEM_LAT+3 cycles: mem_en one cycle
  // after the sampled request, response MEM_LAT+2 cycles after it.
  int cyc = 0;
  int next_free = 0;
  int starve = 0;
  bit chk_on = 1'b0;
  bit g_dm;
  int g_c, r_c, n_c;
  logic [31:0] iss_addr[int], iss_wdata[int], rsp_data[int];
  bit iss_we[int], iss_dm[int], rsp_dm[int], rsp_we[int];
  logic [31:0] model_mem[logic [31:0]];
  logic        e_mem_en, e_mem_we, e_if_valid, e_dm_valid;
  logic [31:0] e_mem_addr, e_mem_wdata, e_if_rdata, e_dm_rdata;

  function automatic logic [31:0] model_rd(input logic [31:0] addr);
    return model_mem.exists(addr) ? model_mem[addr] : mem_init(addr);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      iss_addr.delete(); iss_wdata.delete(); iss_we.delete(); iss_dm.delete();
      rsp_data.delete(); rsp_dm.delete(); rsp_we.delete();
      next_free = cyc + 1;
      starve = 0;
      e_mem_en = 0; e_mem_we = 0; e_if_valid = 0; e_dm_valid = 0;
      e_mem_addr = 0; e_mem_wdata = 0; e_if_rdata = 0; e_dm_rdata = 0;
    end else begin
      if (cyc >= next_free && (a.if_req || a.dm_req)) begin
        g_dm = a.dm_req && !(a.if_req && starve == STARVE_MAX);
        g_c = cyc + 1;
        r_c = cyc + MEM_LAT + 2;
        next_free = cyc + MEM_LAT + 3;
        iss_dm[g_c] = g_dm;
        rsp_dm[r_c] = g_dm;
        if (g_dm) begin
          iss_addr[g_c] = a.dm_addr; iss_we[g_c] = a.dm_we; iss_wdata[g_c] = a.dm_wdata;
          rsp_we[r_c] = a.dm_we;
          if (a.dm_we) begin
            model_mem[a.dm_addr] = a.dm_wdata;
            rsp_data[r_c] = 0;
          end else begin
            rsp_data[r_c] = model_rd(a.dm_addr);
          end
          if (a.if_req && starve < STARVE_MAX) starve++;
        end else begin
          iss_addr[g_c] = a.if_addr; iss_we[g_c] = 0; iss_wdata[g_c] = 0;
          rsp_we[r_c] = 0;
          rsp_data[r_c] = model_rd(a.if_addr);
          starve = 0;
        end
      end
      n_c = cyc + 1;
      e_mem_en = iss_addr.exists(n_c);
      e_mem_we = 0;
      if (e_mem_en) begin
        e_mem_we = iss_we[n_c];
        e_mem_addr = iss_addr[n_c];
        if (iss_dm[n_c]) e_mem_wdata = iss_wdata[n_c];
      end
      e_if_valid = 0;
      e_dm_valid = 0;
      if (rsp_dm.exists(n_c)) begin
        e_if_valid = !rsp_dm[n_c];
        e_dm_valid = rsp_dm[n_c];
        if (e_if_valid) e_if_rdata = rsp_data[n_c];
        if (e_dm_valid && !rsp_we[n_c]) e_dm_rdata = rsp_data[n_c];
      end
    end
    cyc = cyc + 1;
    chk_on = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("mem_en",    32'(a.mem_en),   32'(e_mem_en));
      chk("mem_we",    32'(a.mem_we),   32'(e_mem_we));
      chk("mem_addr",  a.mem_addr,      e_mem_addr);
      chk("mem_wdata", a.mem_wdata,     e_mem_wdata);
      chk("if_valid",  32'(a.if_valid), 32'(e_if_valid));
      chk("dm_valid",  32'(a.dm_valid), 32'(e_dm_valid));
      chk("if_rdata",  a.if_rdata,      e_if_rdata);
      chk("dm_rdata",  a.dm_rdata,      e_dm_rdata);
      chk("stall_if",  32'(a.stall_if), 32'(a.if_req & ~e_if_valid));
      chk("stall_dm",  32'(a.stall_dm), 32'(a.dm_req & ~e_dm_valid));
    end
  end

  // ---------------- event log for literal checks ----------------
  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
  } ev_t;
  ev_t en_q[$], ifv_q[$], dmv_q[$];
  int sif_cnt = 0;

  always @(negedge clk) begin
    if (a.mem_en)   en_q.push_back('{cyc: cyc, addr: a.mem_addr, data: a.mem_wdata, we: a.mem_we});
    if (a.if_valid) ifv_q.push_back('{cyc: cyc, addr: 32'h0, data: a.if_rdata, we: 1'b0});
    if (a.dm_valid) dmv_q.push_back('{cyc: cyc, addr: 32'h0, data: a.dm_rdata, we: 1'b0});
    if (a.stall_if) sif_cnt++;
  end

  function automatic int en_cyc(input int i);
    return (i < en_q.size()) ? en_q[i].cyc : -1000;
  endfunction
  function automatic logic [31:0] en_addr(input int i);
    return (i < en_q.size()) ? en_q[i].addr : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] en_wd(input int i);
    return (i < en_q.size()) ? en_q[i].data : 32'hFFFF_FFFF;
  endfunction
  function automatic logic en_we(input int i);
    return (i < en_q.size()) ? en_q[i].we : 1'bx;
  endfunction
  function automatic int ifv_cyc(input int i);
    return (i < ifv_q.size()) ? ifv_q[i].cyc : -1000;
  endfunction
  function automatic logic [31:0] ifv_dat(input int i);
    return (i < ifv_q.size()) ? ifv_q[i].data : 32'hFFFF_FFFF;
  endfunction
  function automatic int dmv_cyc(input int i);
    return (i < dmv_q.size()) ? dmv_q[i].cyc : -1000;
  endfunction
  function automatic logic [31:0] dmv_dat(input int i);
    return (i < dmv_q.size()) ? dmv_q[i].data : 32'hFFFF_FFFF;
  endfunction

  task automatic clear_logs();
    en_q.delete(); ifv_q.delete(); dmv_q.delete();
    sif_cnt = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic run(input int n, input bit renew_if, input bit renew_dm, output bit idle);
    bit sif, sdm;
    idle = 0;
    for (int i = 0; i < n; i++) begin
      if (!a.if_req && !a.dm_req) break;
      @(negedge clk);
      sif = a.if_valid;
      sdm = a.dm_valid;
      @(posedge clk); #1;
      if (sif && !renew_if) a.if_req = 0;
      if (sdm && !renew_dm) a.dm_req = 0;
    end
    idle = !a.if_req && !a.dm_req;
  endtask

  task automatic drain(input string name, input int n);
    bit idle;
    run(n, 0, 0, idle);
    chk(name, 32'(idle), 32'd1);
  endtask

  int l1_cyc = -1000, l5_cyc = -1000;
  logic [31:0] l1_dat = '0, l5_dat = '0;

  task automatic lat_drive(input int n);
    bit v1, v5;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      v1 = l1.if_valid;
      v5 = l5.if_valid;
      if (v1) begin l1_cyc = cyc; l1_dat = l1.if_rdata; end
      if (v5) begin l5_cyc = cyc; l5_dat = l5.if_rdata; end
      @(posedge clk); #1;
      if (v1) l1.if_req = 0;
      if (v5) l5.if_req = 0;
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  int t0, t1;
  bit run_idle;

  initial begin
    rst_n = 0;
    a.if_req = 0; a.if_addr = 0; a.dm_req = 0; a.dm_we = 0; a.dm_addr = 0; a.dm_wdata = 0;
    l1.if_req = 0; l1.if_addr = 0; l1.dm_req = 0; l1.dm_we = 0; l1.dm_addr = 0; l1.dm_wdata = 0;
    l5.if_req = 0; l5.if_addr = 0; l5.dm_req = 0; l5.dm_we = 0; l5.dm_addr = 0; l5.dm_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state",    32'(dbg_state), 32'(IDLE));
    chk("rst_mem_en",   32'(a.mem_en),  32'd0);
    chk("rst_mem_addr", a.mem_addr,     32'd0);
    chk("rst_if_rdata", a.if_rdata,     32'd0);

    // Single fetch in the first cycle out of reset, plus latency variants.
    @(posedge clk); #1;
    rst_n = 1;
    clear_logs();
    t0 = cyc;
    a.if_req = 1; a.if_addr = 32'h10;
    l1.if_req = 1; l1.if_addr = 32'h30;
    l5.if_req = 1; l5.if_addr = 32'h30;
    fork
      drain("t1_done", 20);
      lat_drive(16);
    join
    chk("t1_en_lat",   32'(en_cyc(0) - t0),  32'd1);
    chk("t1_en_addr",  en_addr(0),           32'h10);
    chk("t1_if_lat",   32'(ifv_cyc(0) - t0), 32'd4);
    chk("t1_if_data",  ifv_dat(0),           32'h8C01_0004);
    chk("t1_stall_n",  32'(sif_cnt),         32'd4);
    chk("lat1_lat",    32'(l1_cyc - t0),     32'd3);
    chk("lat1_data",   l1_dat,               32'hA5A5_0030);
    chk("lat5_lat",    32'(l5_cyc - t0),     32'd7);
    chk("lat5_data",   l5_dat,               32'hA5A5_0030);

    // Collision: data first, fetch follows.
    clear_logs();
    t0 = cyc;
    a.if_addr = 32'h14; a.dm_addr = 32'h20; a.dm_we = 0;
    a.if_req = 1; a.dm_req = 1;
    drain("t2_done", 30);
    chk("t2_dm_lat",    32'(dmv_cyc(0) - t0), 32'd4);
    chk("t2_dm_data",   dmv_dat(0),           32'hA5A5_0020);
    chk("t2_if_en_lat", 32'(en_cyc(1) - t0),  32'd6);
    chk("t2_if_en_adr", en_addr(1),           32'h14);
    chk("t2_if_lat",    32'(ifv_cyc(0) - t0), 32'd9);
    chk("t2_if_data",   ifv_dat(0),           32'hA5A5_0014);

    // Store: one write strobe, dm_rdata keeps the previous load.
    clear_logs();
    t0 = cyc;
    a.dm_we = 1; a.dm_addr = 32'h40; a.dm_wdata = 32'hDEAD_BEEF; a.dm_req = 1;
    drain("t3_done", 20);
    chk("t3_en_count", 32'(en_q.size()),     32'd1);
    chk("t3_en_lat",   32'(en_cyc(0) - t0),  32'd1);
    chk("t3_we",       32'(en_we(0)),        32'd1);
    chk("t3_addr",     en_addr(0),           32'h40);
    chk("t3_wdata",    en_wd(0),             32'hDEAD_BEEF);
    chk("t3_dm_lat",   32'(dmv_cyc(0) - t0), 32'd4);
    chk("t3_dm_hold",  dmv_dat(0),           32'hA5A5_0020);
    a.dm_we = 0;

    // Load back the stored word.
    clear_logs();
    t0 = cyc;
    a.dm_addr = 32'h40; a.dm_req = 1;
    drain("t3b_done", 20);
    chk("t3b_dm_lat",  32'(dmv_cyc(0) - t0), 32'd4);
    chk("t3b_dm_data", dmv_dat(0),           32'hDEAD_BEEF);

    // Starvation: both keep requesting; four data grants then one fetch.
    clear_logs();
    a.if_addr = 32'h100; a.dm_addr = 32'h200;
    a.if_req = 1; a.dm_req = 1;
    run(60, 1, 1, run_idle);
    drain("t4_done", 40);
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < STARVE_MAX; j++) exp_q.push_back(32'h200);
      exp_q.push_back(32'h100);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("t4_grant%0d", i), en_addr(i), exp_q[i]);
    end

    // Reset in the middle of WAIT discards the fetch.
    clear_logs();
    t0 = cyc;
    a.if_addr = 32'h10; a.if_req = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5_in_wait", 32'(dbg_state), 32'(WAIT));
    rst_n = 0; a.if_req = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("t5_mem_en",    32'(a.mem_en),   32'd0);
    chk("t5_mem_we",    32'(a.mem_we),   32'd0);
    chk("t5_mem_addr",  a.mem_addr,      32'd0);
    chk("t5_mem_wdata", a.mem_wdata,     32'd0);
    chk("t5_if_rdata",  a.if_rdata,      32'd0);
    chk("t5_dm_rdata",  a.dm_rdata,      32'd0);
    chk("t5_state",     32'(dbg_state),  32'(IDLE));
    @(posedge clk); #1;
    t1 = cyc;
    a.if_req = 1;
    drain("t5_done", 20);
    chk("t5_if_count", 32'(ifv_q.size()),    32'd1);
    chk("t5_if_lat",   32'(ifv_cyc(0) - t1), 32'd4);
    chk("t5_if_data",  ifv_dat(0),           32'h8C01_0004);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
